fpu: RTL and testbench
======================

// Module: fpu
//
// PURPOSE
//   Multi-cycle IEEE-754 single-precision floating-point unit.
//   Performs add, subtract or multiply on two 32-bit operands.
//   Uses a ready/ack handshake on both input and output sides.
//   Sits beside the integer datapath; the core or testbench drives it as a
//   request/response slave.
//
// PARAMETERS
//   none (binary32 fixed: 1 sign, 8 exponent (bias 127), 23 mantissa bits)
//
// PORTS
//   clock       in   1   single clock, rising edge
//   reset       in   1   asynchronous, active-low reset
//   operation   in   4   0000 add, 0001 sub (a-b), 0010 mul; others unsupported
//   data_a      in   32  operand A (binary32)
//   data_b      in   32  operand B (binary32)
//   input_rdy   in   1   requester has valid operands/operation
//   input_ack   out  1   operands captured; held high until the transaction retires
//   output_rdy  out  1   result valid; held until output_ack
//   output_ack  in   1   requester consumed result
//   result      out  32  binary32 result
//
// BEHAVIOUR
// - Reset (reset=0, async): FSM to IDLE; input_ack=0, output_rdy=0, result=0.
//   Reset mid-operation aborts the transaction; nothing is retained.
// - FSM states: IDLE -> UNPACK -> ALIGN -> EXEC -> NORM -> DONE -> IDLE.
//   - IDLE: on input_rdy=1, latch data_a/data_b/operation, set input_ack=1, go UNPACK.
//   - UNPACK: split fields; detect NaN/Inf/zero/denormal.
//     If a special case applies, write result and go DONE.
//   - ALIGN: add/sub only: right-shift the smaller-exponent significand by the
//     exponent difference (shift >= 26 yields 0). Keep guard bits internally.
//   - EXEC: add/sub: signed-magnitude add with 24-bit significands incl. hidden 1.
//     Mul: 24x24 -> 48-bit product; exponent = ea + eb - 127.
//   - NORM: single-cycle leading-zero count and shift; adjust exponent.
//   - DONE: output_rdy=1, result stable. On output_ack=1, go IDLE next edge and
//     clear input_ack/output_rdy.
// - Latency: regular case output_rdy is high 5 cycles after the capture edge;
//   special-case early exit takes 2 cycles. Latency is fixed per path.
// - input_ack stays 1 from capture through DONE, so output_rdy&&input_ack
//   identifies a live result.
// - Operands changing after capture are ignored. input_rdy held high re-captures
//   in the cycle after IDLE is re-entered.
// - Rounding: truncation (round toward zero); guard bits are discarded.
// - Sub: implemented as add with B sign inverted.
// - Result sign: sign of the larger-magnitude operand.
//   Exact cancellation (x + -x) gives +0 (0x00000000).
// - Mul sign: sa ^ sb.
// - Denormal inputs are treated as zero.
// - Underflow (exp <= 0): signed zero.
// - Overflow (exp >= 255): signed Inf.
// - Special cases (checked in priority order):
//   1. Any NaN operand -> canonical NaN 0xFFFFFFFF.
//   2. Inf + -Inf (effective subtract) -> NaN 0xFFFFFFFF.
//   3. Inf op finite -> that Inf with its sign; for sub, B's Inf sign is negated.
//   4. Mul Inf*0 -> NaN 0xFFFFFFFF; Inf*x -> signed Inf.
//   5. Zero operand on add -> the other operand; on mul -> signed zero.
// - Unsupported operation codes produce 0xFFFFFFFF through the normal handshake.
//
// TESTING
// - add 0x3F800000 (1.0) + 0x3C23D70A (0.01) -> 0x3F8147AE; output_rdy & input_ack high together.
// - add 0x41A80000 (21.0) + 0x3E947AE1 (0.29) -> 0x41AA51EB.
// - add 0xBF800000 (-1.0) + 0xC1433333 (-12.2) -> 0xC1533333; -1.0 + 12.2 (0x41433333) -> 0x41333333.
// - add 0x7E967699 (1e38) + 0xBF8CCCCD (-1.1) -> 0x7E967699 (small operand fully shifted out).
// - specials: +Inf + -1.1 -> 0x7F800000; Inf + 1.0 -> 0x7F800000; NaN + NaN -> 0xFFFFFFFF;
//   +Inf - +Inf -> 0xFFFFFFFF.
// - mul 2.0*2.0 (0x40000000) -> 0x40800000; -2.0*2.0 -> 0xC0800000.
//   Handshake: output_rdy holds until output_ack, then drops.
//   Async reset mid-EXEC clears all outputs immediately.

Source files
------------

// File: rtl/fpu.sv
`default_nettype none
// ============================================================================
// Module      : fpu
// Description : Multi-cycle binary32 add / sub / mul unit with ready/ack
//               handshake on both sides. Truncating rounding, denormals
//               treated as zero, canonical NaN 0xFFFFFFFF.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  operation,
    input  logic [31:0] data_a,
    input  logic [31:0] data_b,
    input  logic        input_rdy,
    output logic        input_ack,
    output logic        output_rdy,
    input  logic        output_ack,
    output logic [31:0] result
);
    localparam logic [3:0]  c_OP_ADD  = 4'b0000;
    localparam logic [3:0]  c_OP_SUB  = 4'b0001;
    localparam logic [3:0]  c_OP_MUL  = 4'b0010;
    localparam logic [31:0] c_NAN     = 32'hFFFF_FFFF;
    localparam logic [30:0] c_INF_MAG = 31'h7F80_0000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_ALIGN  = 3'd2,
        S_EXEC   = 3'd3,
        S_NORM   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t r_state, w_next;

    logic [31:0] r_a, r_b, r_result;
    logic [3:0]  r_op;
    logic        r_sa, r_sb, r_sign;
    logic [7:0]  r_ea, r_eb;
    logic [23:0] r_ma, r_mb;
    logic [26:0] r_big, r_small;
    logic [47:0] r_sig;
    logic signed [9:0] r_exp;

    // Field views of the captured operands; B's sign is flipped for sub
    logic [7:0] w_ea, w_eb;
    logic       w_sa, w_sb, w_is_add, w_is_mul;
    logic       w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    assign w_ea     = r_a[30:23];
    assign w_eb     = r_b[30:23];
    assign w_sa     = r_a[31];
    assign w_sb     = r_b[31] ^ (r_op == c_OP_SUB);
    assign w_is_add = (r_op == c_OP_ADD) || (r_op == c_OP_SUB);
    assign w_is_mul = (r_op == c_OP_MUL);
    assign w_a_nan  = (&w_ea) && (|r_a[22:0]);
    assign w_b_nan  = (&w_eb) && (|r_b[22:0]);
    assign w_a_inf  = (&w_ea) && !(|r_a[22:0]);
    assign w_b_inf  = (&w_eb) && !(|r_b[22:0]);
    assign w_a_zero = (w_ea == 8'd0);   // denormals collapse to zero
    assign w_b_zero = (w_eb == 8'd0);

    // Special-case detection in priority order; unsupported ops fall into NaN
    logic        w_special;
    logic [31:0] w_special_res;
    always_comb begin
        w_special     = 1'b1;
        w_special_res = c_NAN;
        if (!w_is_add && !w_is_mul) begin
            w_special_res = c_NAN;
        end else if (w_a_nan || w_b_nan) begin
            w_special_res = c_NAN;
        end else if (w_is_add) begin
            if (w_a_inf && w_b_inf && (w_sa != w_sb)) w_special_res = c_NAN;
            else if (w_a_inf)                          w_special_res = {w_sa, c_INF_MAG};
            else if (w_b_inf)                          w_special_res = {w_sb, c_INF_MAG};
            else if (w_a_zero && w_b_zero)             w_special_res = {w_sa & w_sb, 31'd0};
            else if (w_a_zero)                         w_special_res = {w_sb, r_b[30:0]};
            else if (w_b_zero)                         w_special_res = {w_sa, r_a[30:0]};
            else                                       w_special = 1'b0;
        end else begin
            if ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) w_special_res = c_NAN;
            else if (w_a_inf || w_b_inf)   w_special_res = {w_sa ^ w_sb, c_INF_MAG};
            else if (w_a_zero || w_b_zero) w_special_res = {w_sa ^ w_sb, 31'd0};
            else                           w_special = 1'b0;
        end
    end

    // Alignment: larger magnitude stays put, smaller shifts right with 3 guard bits
    logic        w_swap;
    logic [7:0]  w_diff;
    logic [26:0] w_small_sh;
    logic [27:0] w_sum;
    always_comb begin
        w_swap     = {r_eb, r_mb} > {r_ea, r_ma};
        w_diff     = w_swap ? (r_eb - r_ea) : (r_ea - r_eb);
        w_small_sh = 27'd0;
        if (w_diff < 8'd26)
            w_small_sh = {(w_swap ? r_ma : r_mb), 3'b000} >> w_diff;
        w_sum = (r_sa != r_sb) ? ({1'b0, r_big} - {1'b0, r_small})
                               : ({1'b0, r_big} + {1'b0, r_small});
    end

    // Normalisation: hidden bit belongs at r_sig[46]; bit 47 means carry-out
    logic [5:0]        w_lz;
    logic              w_found;
    logic [22:0]       w_mant;
    logic signed [9:0] w_nexp;
    logic [31:0]       w_norm_res;
    always_comb begin
        w_lz    = 6'd0;
        w_found = 1'b0;
        for (int i = 46; i >= 0; i--) begin
            if (!w_found && r_sig[i]) begin
                w_lz    = 6'(46 - i);
                w_found = 1'b1;
            end
        end
        if (r_sig[47]) begin
            w_mant = r_sig[46:24];
            w_nexp = r_exp + 10'sd1;
        end else begin
            w_mant = 23'((r_sig[45:0] << w_lz) >> 23);
            w_nexp = r_exp - $signed({4'b0000, w_lz});
        end
        if (r_sig == 48'd0)           w_norm_res = 32'd0;   // exact cancellation is +0
        else if (w_nexp <= 10'sd0)    w_norm_res = {r_sign, 31'd0};
        else if (w_nexp >= 10'sd255)  w_norm_res = {r_sign, c_INF_MAG};
        else                          w_norm_res = {r_sign, w_nexp[7:0], w_mant};
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; every path has a fixed cycle count
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (input_rdy) w_next = S_UNPACK;
            S_UNPACK: w_next = w_special ? S_DONE : S_ALIGN;
            S_ALIGN:  w_next = S_EXEC;
            S_EXEC:   w_next = S_NORM;
            S_NORM:   w_next = S_DONE;
            S_DONE:   if (output_ack) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Datapath registers advanced one stage per state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_a <= '0; r_b <= '0; r_op <= '0; r_result <= '0;
            r_sa <= 1'b0; r_sb <= 1'b0; r_sign <= 1'b0;
            r_ea <= '0; r_eb <= '0; r_ma <= '0; r_mb <= '0;
            r_big <= '0; r_small <= '0; r_sig <= '0; r_exp <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (input_rdy) begin
                    r_a  <= data_a;
                    r_b  <= data_b;
                    r_op <= operation;
                end
                S_UNPACK: begin
                    if (w_special) r_result <= w_special_res;
                    r_sa <= w_sa;
                    r_sb <= w_sb;
                    r_ea <= w_ea;
                    r_eb <= w_eb;
                    r_ma <= {1'b1, r_a[22:0]};
                    r_mb <= {1'b1, r_b[22:0]};
                end
                S_ALIGN: if (w_is_add) begin
                    r_big   <= {(w_swap ? r_mb : r_ma), 3'b000};
                    r_small <= w_small_sh;
                    r_exp   <= $signed({2'b00, (w_swap ? r_eb : r_ea)});
                    r_sign  <= w_swap ? r_sb : r_sa;
                end
                S_EXEC: begin
                    if (w_is_add) begin
                        r_sig <= {w_sum, 20'd0};
                    end else begin
                        r_sig  <= {24'd0, r_ma} * {24'd0, r_mb};
                        r_exp  <= $signed({2'b00, r_ea}) + $signed({2'b00, r_eb}) - 10'sd127;
                        r_sign <= r_sa ^ r_sb;
                    end
                end
                S_NORM:  r_result <= w_norm_res;
                default: ;
            endcase
        end
    end

    assign input_ack  = (r_state != S_IDLE);
    assign output_rdy = (r_state == S_DONE);
    assign result     = r_result;

endmodule
`default_nettype wire

// File: tb/tb_fpu.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu
// Description : Directed self-checking bench for fpu with expected-result
//               scoreboard queue and latency/handshake checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  operation = 4'd0;
    logic [31:0] data_a = 32'd0;
    logic [31:0] data_b = 32'd0;
    logic        input_rdy = 1'b0;
    logic        input_ack;
    logic        output_rdy;
    logic        output_ack = 1'b0;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb_q[$];

    fpu dut (
        .clock      (clock),
        .reset      (reset),
        .operation  (operation),
        .data_a     (data_a),
        .data_b     (data_b),
        .input_rdy  (input_rdy),
        .input_ack  (input_ack),
        .output_rdy (output_rdy),
        .output_ack (output_ack),
        .result     (result)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction; latency counts the capture edge as edge 1
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat,
                          input int hold);
        int cyc;
        logic [31:0] exp_q;
        logic [31:0] held;
        sb_q.push_back(exp_res);
        @(negedge clock);
        operation = op; data_a = a; data_b = b; input_rdy = 1'b1;
        @(posedge clock); #1;
        cyc = 1;
        input_rdy = 1'b0;
        data_a = 32'h1234_5678; data_b = 32'h8765_4321; operation = 4'd0;
        check({tag, "_ack"}, {31'd0, input_ack}, 32'd1);
        while (!output_rdy && cyc < 20) begin
            @(posedge clock); #1;
            cyc++;
        end
        check({tag, "_lat"}, cyc, exp_lat);
        check({tag, "_live"}, {31'd0, output_rdy & input_ack}, 32'd1);
        exp_q = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
        check({tag, "_res"}, result, exp_q);
        held = result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            check({tag, "_hold_rdy"}, {31'd0, output_rdy}, 32'd1);
            check({tag, "_hold_res"}, result, held);
        end
        @(negedge clock);
        output_ack = 1'b1;
        @(posedge clock); #1;
        output_ack = 1'b0;
        check({tag, "_drop"}, {30'd0, output_rdy, input_ack}, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_ack", {31'd0, input_ack}, 32'd0);
        check("rst_rdy", {31'd0, output_rdy}, 32'd0);
        check("rst_res", result, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        run_op("add_1_001",   4'b0000, 32'h3F800000, 32'h3C23D70A, 32'h3F8147AE, 5, 0);
        run_op("add_21_029",  4'b0000, 32'h41A80000, 32'h3E947AE1, 32'h41AA51EB, 5, 0);
        run_op("add_neg_neg", 4'b0000, 32'hBF800000, 32'hC1433333, 32'hC1533333, 5, 0);
        run_op("add_neg_pos", 4'b0000, 32'hBF800000, 32'h41433333, 32'h41333333, 5, 0);
        run_op("add_shift_out", 4'b0000, 32'h7E967699, 32'hBF8CCCCD, 32'h7E967699, 5, 0);
        run_op("inf_plus_neg", 4'b0000, 32'h7F800000, 32'hBF8CCCCD, 32'h7F800000, 2, 0);
        run_op("inf_plus_one", 4'b0000, 32'h7F800000, 32'h3F800000, 32'h7F800000, 2, 0);
        run_op("nan_nan",     4'b0000, 32'h7FC00000, 32'h7FC00000, 32'hFFFFFFFF, 2, 0);
        run_op("inf_sub_inf", 4'b0001, 32'h7F800000, 32'h7F800000, 32'hFFFFFFFF, 2, 0);
        run_op("mul_2x2",     4'b0010, 32'h40000000, 32'h40000000, 32'h40800000, 5, 3);
        run_op("mul_m2x2",    4'b0010, 32'hC0000000, 32'h40000000, 32'hC0800000, 5, 0);
        run_op("mul_15x15",   4'b0010, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 5, 0);
        run_op("cancel_add",  4'b0000, 32'h3F800000, 32'hBF800000, 32'h00000000, 5, 0);
        run_op("cancel_sub",  4'b0001, 32'h3F800000, 32'h3F800000, 32'h00000000, 5, 0);
        run_op("sub_1_2",     4'b0001, 32'h3F800000, 32'h40000000, 32'hBF800000, 5, 0);
        run_op("add_ovf",     4'b0000, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 5, 0);
        run_op("mul_unf",     4'b0010, 32'h00800000, 32'h00800000, 32'h00000000, 5, 0);
        run_op("mul_inf_zero", 4'b0010, 32'h7F800000, 32'h00000000, 32'hFFFFFFFF, 2, 0);
        run_op("add_zero",    4'b0000, 32'h00000000, 32'h3FC00000, 32'h3FC00000, 2, 0);
        run_op("mul_denorm",  4'b0010, 32'h00000001, 32'h40000000, 32'h00000000, 2, 0);
        run_op("bad_op",      4'b0011, 32'h3F800000, 32'h3F800000, 32'hFFFFFFFF, 2, 0);

        // Abort a transaction in EXEC with an asynchronous reset
        @(negedge clock);
        operation = 4'b0000; data_a = 32'h3F800000; data_b = 32'h3C23D70A; input_rdy = 1'b1;
        @(posedge clock); #1;
        input_rdy = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("abort_ack", {31'd0, input_ack}, 32'd0);
        check("abort_rdy", {31'd0, output_rdy}, 32'd0);
        check("abort_res", result, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        run_op("post_reset",  4'b0010, 32'hC0000000, 32'h40000000, 32'hC0800000, 5, 0);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
